alu: RTL and testbench

- Arithmetic unit of a TIS-100 style execution node.
- Combines the accumulator (acc) with a source operand (src) according to a 2-bit opcode.
- Produces a result saturated to the node value range −999..+999.
- Result is available combinationally for the node's ACC write-back; a registered copy is also provided for pipelined consumers.

---
 rtl/tis_pkg.sv | 19 +
 rtl/sat_clamp.sv | 32 +++
 rtl/alu.sv | 60 ++++++
 tb/tb_alu.sv | 136 +++++++++++++
 4 files changed

// File: rtl/tis_pkg.sv
// Shared definitions for the TIS-100 style execution node.
// Holds the node word geometry, the saturation magnitude, the ALU opcode
// encodings and the signed word types used across the node.
package tis_pkg;

  localparam int DATA_W  = 11;   // node word width, two's complement
  localparam int MAX_VAL = 999;  // node values live in [-MAX_VAL, +MAX_VAL]

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NEG  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  // Node word, and the one-bit-wider word that holds any raw ALU result
  // exactly before clamping.
  typedef logic signed [DATA_W-1:0] word_t;
  typedef logic signed [DATA_W:0]   wide_t;

endpackage

// File: rtl/sat_clamp.sv
// Saturating narrower for node values.
// Takes an exact (DATA_W+1)-bit signed value and clamps it into
// [-MAX_VAL, +MAX_VAL], returning a DATA_W-bit signed word.
// Shared by the ALU and the node I/O path.
//   din  : (DATA_W+1)-bit signed raw value
//   dout : DATA_W-bit signed saturated value
module sat_clamp
  import tis_pkg::*;
#(
  parameter int DW  = DATA_W,
  parameter int MAX = MAX_VAL
) (
  input  logic signed [DW:0]   din,
  output logic signed [DW-1:0] dout
);

  // Limits at the wide width for comparison, and at the output width for
  // driving the result.
  localparam logic signed [DW:0]   HI_W = (DW+1)'(MAX);
  localparam logic signed [DW:0]   LO_W = (DW+1)'(-MAX);
  localparam logic signed [DW-1:0] HI_N = DW'(MAX);
  localparam logic signed [DW-1:0] LO_N = DW'(-MAX);

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch
    // is inferred if a branch is later edited out.
    dout = din[DW-1:0];
    if (din > HI_W)      dout = HI_N;
    else if (din < LO_W) dout = LO_N;
  end

endmodule

// File: rtl/alu.sv
// Arithmetic unit of a TIS-100 style execution node.
// Combines the accumulator with a source operand, saturating the result to
// the node range. The result is offered combinationally for ACC write-back
// and as a registered copy for pipelined consumers.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, clears out_q only
//   instr : 00 ADD, 01 SUB, 10 NEG, 11 PASS
//   acc   : accumulator operand, signed
//   src   : source operand, signed
//   en    : load enable for out_q
//   out   : combinational saturated result
//   out_q : registered copy of out
module alu
  import tis_pkg::*;
#(
  parameter int DW  = DATA_W,
  parameter int MAX = MAX_VAL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           instr,
  input  logic signed [DW-1:0] acc,
  input  logic signed [DW-1:0] src,
  input  logic                 en,
  output logic signed [DW-1:0] out,
  output logic signed [DW-1:0] out_q
);

  // One extra bit is enough to hold every result exactly: the extremes are
  // -1024 - 1023 = -2047 and -(-1024) = +1024.
  logic signed [DW:0] acc_x;
  logic signed [DW:0] src_x;
  logic signed [DW:0] raw;

  assign acc_x = {acc[DW-1], acc};
  assign src_x = {src[DW-1], src};

  always_comb begin
    raw = '0;
    case (instr)
      OP_ADD:  raw = acc_x + src_x;
      OP_SUB:  raw = acc_x - src_x;
      OP_NEG:  raw = -acc_x;
      OP_PASS: raw = src_x;  // MOV-to-ACC; still clamped like everything else
    endcase
  end

  sat_clamp #(.DW(DW), .MAX(MAX)) u_clamp (
    .din  (raw),
    .dout (out)
  );

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst)     out_q <= '0;
    else if (en) out_q <= out;
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the node ALU: directed vector table, register-path
// sequences and a randomized sweep against an integer reference model.
module tb_alu;
  import tis_pkg::*;

  logic              clk;
  logic              rst;
  logic [1:0]        instr;
  logic signed [10:0] acc;
  logic signed [10:0] src;
  logic              en;
  logic signed [10:0] out;
  logic signed [10:0] out_q;

  int n_pass  = 0;
  int n_total = 0;

  alu dut (
    .clk   (clk),
    .rst   (rst),
    .instr (instr),
    .acc   (acc),
    .src   (src),
    .en    (en),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]         op;
    logic signed [10:0] a;
    logic signed [10:0] s;
    logic signed [10:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic signed [10:0] act,
                       input logic signed [10:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else
      n_pass++;
  endtask

  // Reference: exact integer arithmetic followed by the clamp.
  function automatic int model(input logic [1:0] op, input int a, input int s);
    int r;
    case (op)
      2'b00:   r = a + s;
      2'b01:   r = a - s;
      2'b10:   r = -a;
      default: r = s;
    endcase
    if (r > 999)  r = 999;
    if (r < -999) r = -999;
    return r;
  endfunction

  initial begin
    vecs[0]  = '{2'b00,     5,     7,    12};
    vecs[1]  = '{2'b00,   -20,     3,   -17};
    vecs[2]  = '{2'b01,    10,    25,   -15};
    vecs[3]  = '{2'b10,   123,   400,  -123};
    vecs[4]  = '{2'b00,   999,     1,   999};
    vecs[5]  = '{2'b01,  -999,   500,  -999};
    vecs[6]  = '{2'b00,  1023,  1023,   999};
    vecs[7]  = '{2'b10, -1024,     0,   999};
    vecs[8]  = '{2'b11,    50,  -300,  -300};
    vecs[9]  = '{2'b11,     0,  1000,   999};
    vecs[10] = '{2'b01,  -999,     1,  -999};
    vecs[11] = '{2'b01,     0,     0,     0};
    vecs[12] = '{2'b01, -1024,  1023,  -999};
    vecs[13] = '{2'b11,   777, -1024,  -999};

    rst = 1'b1; en = 1'b0; instr = 2'b00; acc = '0; src = '0;

    // Reset clears out_q.
    @(posedge clk); #1;
    check("reset_out_q", out_q, 11'sd0);

    // Directed combinational table; en is low so out_q is untouched.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      instr = vecs[i].op; acc = vecs[i].a; src = vecs[i].s;
      #1;
      check($sformatf("vec%0d", i), out, vecs[i].exp);
    end

    // Load 12, then hold it while inputs change with en low.
    @(negedge clk);
    instr = OP_ADD; acc = 11'sd5; src = 11'sd7; en = 1'b1;
    @(posedge clk); #1;
    check("load_12", out_q, 11'sd12);
    @(negedge clk);
    en = 1'b0; instr = OP_SUB; acc = 11'sd300; src = -11'sd200;
    @(posedge clk); #1;
    check("hold_out", out, 11'sd500);
    check("hold_12_a", out_q, 11'sd12);
    @(negedge clk);
    instr = OP_NEG; acc = 11'sd40;
    @(posedge clk); #1;
    check("hold_12_b", out_q, 11'sd12);

    // Load a saturated value, then rst and en together: rst wins.
    @(negedge clk);
    instr = OP_PASS; src = 11'sd1020; en = 1'b1;
    @(posedge clk); #1;
    check("load_sat", out_q, 11'sd999);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_over_en", out_q, 11'sd0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;

    // Randomized sweep over the full input space for every opcode.
    for (int i = 0; i < 400; i++) begin
      instr = 2'(i % 4);
      acc   = 11'($urandom_range(0, 2047));
      src   = 11'($urandom_range(0, 2047));
      #1;
      check($sformatf("rand%0d op%0d %0d,%0d", i, instr, acc, src), out,
            11'(model(instr, int'(acc), int'(src))));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
